pad_bank_ctrl: RTL and testbench
================================

# pad_bank_ctrl

Owner controller for one 16-pin pad bank. Holds per-pin pad configuration (output value, direction, pulls, slew, Schmitt/CS), written through a byte-wide register bus, and arbitrates pin ownership between the CPU register path and one alternate-function peripheral. Sits between the core's peripheral bus and the pad ring, and replaces the fixed-pattern tie-off for banks that become software-usable.

## Interface

Parameters:
- `RST_SEL`, default 16'h0000: reset value of the ownership register (1 = alternate function owns the pin).

Ports:
- `clk_i`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `bus_addr`  in  4  byte address; `[3:1]` selects the register, `[0]` selects the byte (0 = bits 7:0, 1 = bits 15:8).
- `bus_wdata`  in  8  write data.
- `bus_we`  in  1  write strobe, one cycle per access.
- `bus_re`  in  1  read strobe, one cycle per access.
- `bus_rdata`  out  8  read data, valid with `bus_ack`.
- `bus_ack`  out  1  single-cycle access acknowledge.
- `alt_out`  in  16  alternate-function output values.
- `alt_oe`  in  16  alternate-function output enables.
- `alt_in`  out  16  synchronized pad inputs, delivered to the alternate function.
- `io_in`  in  16  raw pad inputs (asynchronous).
- `io_out`, `io_oe`, `io_ie`, `io_cs`, `io_sl`, `io_pu`, `io_pd`  out  16 each  pad controls.

## Operation

- Register map, indexed by `bus_addr[3:1]`: 0 OUT, 1 OE, 2 PU, 3 PD, 4 SL, 5 CS, 6 SEL, 7 IN. IN is read-only, and writes to IN are acknowledged and discarded.
- Reset values: all registers 0 except SEL = `RST_SEL`. Every pin is an input with no pulls.
- Ownership per pin `i`:
  - SEL[i] = 0: `io_out[i]` = OUT[i] and `io_oe[i]` = OE[i].
  - SEL[i] = 1: `io_out[i]` = `alt_out[i]` and `io_oe[i]` = `alt_oe[i]`.
  - PU, PD, SL and CS always come from the registers, whoever owns the pin.
- Pull conflict: when PU[i] and PD[i] are both 1, `io_pu[i]` = 1 and `io_pd[i]` = 0. A pin that is actively driving gets no pulls: `io_oe[i]` = 1 forces `io_pu[i]` and `io_pd[i]` to 0.
- `io_ie` = ~`io_oe`, computed per pin from the post-arbitration enable.
- Input path:
  - `io_in` passes through a 2-flop synchronizer.
  - The synchronizer output feeds `alt_in` and the IN register (no extra stage).
- Bus:
  - The access completes in the cycle of the strobe. `bus_ack` is high exactly one cycle later.
  - `bus_rdata` updates with `bus_ack` and holds until the next read ack. It is 0 after reset.
  - `bus_we` and `bus_re` high together: the access is treated as a write, and `bus_rdata` is unchanged.
  - Strobes arriving on back-to-back cycles are each acknowledged on back-to-back cycles. There is no wait state.
- A byte write modifies only the addressed 8 bits of the register.

## Timing

- Pad outputs are registered. A write sampled on edge N, or any change of `alt_out`/`alt_oe`/SEL sampled on edge N, is visible on the `io_*` pins after edge N, in cycle N+1. Latency is 1 cycle.
- Read of OUT, OE, PU, PD, SL, CS or SEL in the cycle immediately after a write to the same byte returns the new value.
- Input latency: a pad change is visible in IN/`alt_in` 2 to 3 edges after the change (2-flop synchronizer plus sampling).
- Reset mid-access:
  - `rst` in the strobe cycle aborts the access: no register update and no ack.
  - `rst` in the ack cycle forces `bus_ack` = 0.
  - The synchronizer flops reset to 0.
- During reset the pad outputs hold their reset values: `io_oe` = 0, `io_ie` = 16'hFFFF, pulls 0. Alternate drive on SEL pins applies only from the first cycle after reset is released.

## Structure

- Package `pad_ctrl_pkg` contains:
  - the register index constants (`REG_OUT` … `REG_IN`);
  - the register width (16);
  - the reset-value constants.
- Sub-module `pad_sync`: parameterized-width 2-flop synchronizer with synchronous reset. It is instantiated once with width 16.
- The top level holds the register file, the bus FSM (IDLE/ACK, implemented as a single ack flop), the per-pin ownership mux and the output registers.

## Test plan

- Reset with `RST_SEL` = 0:
  - `io_oe` = 0, `io_ie` = 16'hFFFF, `io_pu` = `io_pd` = 0.
  - Read of addr 0xC then 0xD returns 8'h00 / 8'h00.
- Drive a pin from the CPU:
  - Stimulus: write OE lo (addr 2) = 8'h05, then OUT lo (addr 0) = 8'h04.
  - Response: one cycle after the second write, `io_oe` = 16'h0005, `io_out` = 16'h0004, `io_ie` = 16'hFFFA.
- Hand pins to the alternate function:
  - Stimulus: write SEL hi (addr 0xD) = 8'h80, with `alt_oe` = `alt_out` = 16'hFFFF.
  - Response: next cycle `io_oe[15]` = `io_out[15]` = 1, while pins 14:0 still follow the OUT/OE registers.
- Pull rules:
  - PU = PD = 16'h0003 with OE = 0 gives `io_pu` = 16'h0003 and `io_pd` = 0.
  - Then setting OE lo = 8'h01 gives `io_pu` = 16'h0002.
- Inputs and bus edge cases:
  - Step `io_in` to 16'hA55A. A read of IN lo/hi issued 3 cycles later returns 8'h5A / 8'hA5, and `alt_in` = 16'hA55A.
  - Simultaneous `bus_we`/`bus_re` to addr 0: the write lands, one ack is issued, `bus_rdata` is unchanged.
- Reset mid-access: assert `rst` in a write strobe cycle. The target register stays 0 and no `bus_ack` pulse is seen.

Source files
------------

// File: rtl/pad_ctrl_pkg.sv
// Shared constants and types for the pad bank controller: register map, widths, reset values.
// Pure declarations; no logic, no timing.
package pad_ctrl_pkg;

  localparam int REG_W = 16;

  localparam logic [2:0] REG_OUT = 3'd0;
  localparam logic [2:0] REG_OE  = 3'd1;
  localparam logic [2:0] REG_PU  = 3'd2;
  localparam logic [2:0] REG_PD  = 3'd3;
  localparam logic [2:0] REG_SL  = 3'd4;
  localparam logic [2:0] REG_CS  = 3'd5;
  localparam logic [2:0] REG_SEL = 3'd6;
  localparam logic [2:0] REG_IN  = 3'd7;

  localparam logic [REG_W-1:0] RST_REG = '0;
  localparam logic [REG_W-1:0] RST_IE  = '1;

  typedef enum logic {ST_IDLE, ST_ACK} bus_state_t;

  // Replace one byte of a register word, leaving the other byte intact.
  function automatic logic [REG_W-1:0] byte_merge(input logic [REG_W-1:0] cur,
                                                  input logic hi,
                                                  input logic [7:0] wd);
    byte_merge = cur;
    if (hi) byte_merge[15:8] = wd;
    else    byte_merge[7:0]  = wd;
  endfunction

endpackage

// File: rtl/pad_bank_ctrl_if.sv
// Byte-wide register bus between the core and the pad bank controller.
// Strobes are single-cycle; the slave acks one cycle later with no wait states.
interface pad_bank_ctrl_if;
  logic [3:0] bus_addr;
  logic [7:0] bus_wdata;
  logic       bus_we;
  logic       bus_re;
  logic [7:0] bus_rdata;
  logic       bus_ack;

  modport master (output bus_addr, bus_wdata, bus_we, bus_re,
                  input  bus_rdata, bus_ack);
  modport slave  (input  bus_addr, bus_wdata, bus_we, bus_re,
                  output bus_rdata, bus_ack);
endinterface

// File: rtl/pad_sync.sv
// Two-flop synchronizer for asynchronous pad inputs, W bits wide, sync reset to 0.
// Latency 2 edges; no backpressure.
module pad_sync #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk_i) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pad_bank_ctrl.sv
// 16-pin pad bank owner: config registers, CPU/alt-function ownership mux, registered pad drive.
// Pad outputs 1 cycle after a write or alt change; bus acks 1 cycle after the strobe, never stalls.
module pad_bank_ctrl
  import pad_ctrl_pkg::*;
#(
  parameter logic [REG_W-1:0] RST_SEL = 16'h0000
) (
  input  logic             clk_i,
  input  logic             rst,
  pad_bank_ctrl_if.slave   bus,
  input  logic [REG_W-1:0] alt_out,
  input  logic [REG_W-1:0] alt_oe,
  output logic [REG_W-1:0] alt_in,
  input  logic [REG_W-1:0] io_in,
  output logic [REG_W-1:0] io_out,
  output logic [REG_W-1:0] io_oe,
  output logic [REG_W-1:0] io_ie,
  output logic [REG_W-1:0] io_cs,
  output logic [REG_W-1:0] io_sl,
  output logic [REG_W-1:0] io_pu,
  output logic [REG_W-1:0] io_pd
);

  logic [2:0]       idx;
  logic             hi;
  logic [REG_W-1:0] out_q, oe_q, pu_q, pd_q, sl_q, cs_q, sel_q;
  logic [REG_W-1:0] out_n, oe_n, pu_n, pd_n, sl_n, cs_n, sel_n;
  logic [REG_W-1:0] in_sync;
  logic [REG_W-1:0] rd_word;
  logic [REG_W-1:0] drv_oe, drv_out;
  logic [7:0]       rdata_q;
  bus_state_t       state_q;

  assign idx = bus.bus_addr[3:1];
  assign hi  = bus.bus_addr[0];

  pad_sync #(.W(REG_W)) u_sync (
    .clk_i (clk_i),
    .rst   (rst),
    .d     (io_in),
    .q     (in_sync)
  );

  assign alt_in = in_sync;

  // Post-write register image, so pads reflect a write one cycle after its strobe.
  always_comb begin
    out_n = out_q;
    oe_n  = oe_q;
    pu_n  = pu_q;
    pd_n  = pd_q;
    sl_n  = sl_q;
    cs_n  = cs_q;
    sel_n = sel_q;
    if (bus.bus_we) begin
      case (idx)
        REG_OUT: out_n = byte_merge(out_q, hi, bus.bus_wdata);
        REG_OE:  oe_n  = byte_merge(oe_q,  hi, bus.bus_wdata);
        REG_PU:  pu_n  = byte_merge(pu_q,  hi, bus.bus_wdata);
        REG_PD:  pd_n  = byte_merge(pd_q,  hi, bus.bus_wdata);
        REG_SL:  sl_n  = byte_merge(sl_q,  hi, bus.bus_wdata);
        REG_CS:  cs_n  = byte_merge(cs_q,  hi, bus.bus_wdata);
        REG_SEL: sel_n = byte_merge(sel_q, hi, bus.bus_wdata);
        default: ;
      endcase
    end
  end

  always_comb begin
    case (idx)
      REG_OUT: rd_word = out_q;
      REG_OE:  rd_word = oe_q;
      REG_PU:  rd_word = pu_q;
      REG_PD:  rd_word = pd_q;
      REG_SL:  rd_word = sl_q;
      REG_CS:  rd_word = cs_q;
      REG_SEL: rd_word = sel_q;
      default: rd_word = in_sync;
    endcase
  end

  assign drv_oe  = (sel_n & alt_oe)  | (~sel_n & oe_n);
  assign drv_out = (sel_n & alt_out) | (~sel_n & out_n);

  always_ff @(posedge clk_i) begin
    if (rst) begin
      out_q   <= RST_REG;
      oe_q    <= RST_REG;
      pu_q    <= RST_REG;
      pd_q    <= RST_REG;
      sl_q    <= RST_REG;
      cs_q    <= RST_REG;
      sel_q   <= RST_SEL;
      state_q <= ST_IDLE;
      rdata_q <= '0;
      io_out  <= RST_REG;
      io_oe   <= RST_REG;
      io_ie   <= RST_IE;
      io_pu   <= RST_REG;
      io_pd   <= RST_REG;
      io_sl   <= RST_REG;
      io_cs   <= RST_REG;
    end else begin
      out_q   <= out_n;
      oe_q    <= oe_n;
      pu_q    <= pu_n;
      pd_q    <= pd_n;
      sl_q    <= sl_n;
      cs_q    <= cs_n;
      sel_q   <= sel_n;
      state_q <= (bus.bus_we || bus.bus_re) ? ST_ACK : ST_IDLE;
      if (bus.bus_re && !bus.bus_we) begin
        rdata_q <= hi ? rd_word[15:8] : rd_word[7:0];
      end
      io_out <= drv_out;
      io_oe  <= drv_oe;
      io_ie  <= ~drv_oe;
      // Pull-up wins a pull conflict; a driving pin gets no pulls at all.
      io_pu  <= pu_n & ~drv_oe;
      io_pd  <= pd_n & ~pu_n & ~drv_oe;
      io_sl  <= sl_n;
      io_cs  <= cs_n;
    end
  end

  // Reset landing in the ack cycle must cancel the ack immediately.
  assign bus.bus_ack   = (state_q == ST_ACK) && !rst;
  assign bus.bus_rdata = rdata_q;

endmodule

// File: tb/tb_pad_bank_ctrl.sv
// Bench for pad_bank_ctrl: directed vector table, hand sequences for timing corners, random run vs model.
module tb_pad_bank_ctrl;

  localparam logic [15:0] SEL_RST = 16'h0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] alt_out, alt_oe, alt_in, io_in;
  logic [15:0] io_out, io_oe, io_ie, io_cs, io_sl, io_pu, io_pd;

  pad_bank_ctrl_if bus_if();

  pad_bank_ctrl #(.RST_SEL(SEL_RST)) dut (
    .clk_i   (clk),
    .rst     (rst),
    .bus     (bus_if),
    .alt_out (alt_out),
    .alt_oe  (alt_oe),
    .alt_in  (alt_in),
    .io_in   (io_in),
    .io_out  (io_out),
    .io_oe   (io_oe),
    .io_ie   (io_ie),
    .io_cs   (io_cs),
    .io_sl   (io_sl),
    .io_pu   (io_pu),
    .io_pd   (io_pd)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic        r, w, rd;
    logic [3:0]  a;
    logic [7:0]  wd;
    logic [15:0] eo, eoe, epu, epd;
    logic        eack;
    logic [7:0]  erd;
  } vec_t;

  vec_t tbl[18];

  // Reference model: register contents by map index, plus expected pad/bus state.
  logic [15:0] m_reg[0:7];
  logic [15:0] m_in;
  logic [15:0] hist[$];
  logic [15:0] e_out, e_oe, e_pu, e_pd, e_sl, e_cs;
  logic        m_ack;
  logic [7:0]  m_rdata;

  function automatic vec_t mk(logic r, logic w, logic rd, logic [3:0] a, logic [7:0] wd,
                              logic [15:0] eo, logic [15:0] eoe, logic [15:0] epu,
                              logic [15:0] epd, logic eack, logic [7:0] erd);
    vec_t v;
    v.r = r; v.w = w; v.rd = rd; v.a = a; v.wd = wd;
    v.eo = eo; v.eoe = eoe; v.epu = epu; v.epd = epd; v.eack = eack; v.erd = erd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic drive(input logic r, input logic w, input logic rd,
                       input logic [3:0] a, input logic [7:0] wd);
    rst = r;
    bus_if.bus_we    = w;
    bus_if.bus_re    = rd;
    bus_if.bus_addr  = a;
    bus_if.bus_wdata = wd;
  endtask

  task automatic model_edge();
    int          idx;
    int          b;
    logic [15:0] rd16;
    logic        own, drv;
    idx = int'(bus_if.bus_addr[3:1]);
    b   = int'(bus_if.bus_addr[0]);
    if (rst) begin
      for (int r = 0; r < 8; r++) m_reg[r] = 16'h0;
      m_reg[6] = SEL_RST;
      m_ack = 1'b0; m_rdata = 8'h00; m_in = 16'h0;
      hist.push_back(16'h0);
      e_out = 16'h0; e_oe = 16'h0; e_pu = 16'h0; e_pd = 16'h0; e_sl = 16'h0; e_cs = 16'h0;
    end else begin
      if (idx == 7) rd16 = m_in;
      else          rd16 = m_reg[idx];
      if (bus_if.bus_re && !bus_if.bus_we) m_rdata = rd16[b*8 +: 8];
      if (bus_if.bus_we && idx != 7) m_reg[idx][b*8 +: 8] = bus_if.bus_wdata;
      m_ack = bus_if.bus_we | bus_if.bus_re;
      m_in = hist[$];
      hist.push_back(io_in);
      for (int i = 0; i < 16; i++) begin
        own = m_reg[6][i];
        drv = own ? alt_oe[i] : m_reg[1][i];
        e_out[i] = own ? alt_out[i] : m_reg[0][i];
        e_oe[i]  = drv;
        e_pu[i]  = !drv && m_reg[2][i];
        e_pd[i]  = !drv && m_reg[3][i] && !m_reg[2][i];
      end
      e_sl = m_reg[4];
      e_cs = m_reg[5];
    end
    if (hist.size() > 4) void'(hist.pop_front());
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic check_model();
    chk("rnd_io_out", io_out, e_out);
    chk("rnd_io_oe",  io_oe,  e_oe);
    chk("rnd_io_ie",  io_ie,  ~e_oe);
    chk("rnd_io_pu",  io_pu,  e_pu);
    chk("rnd_io_pd",  io_pd,  e_pd);
    chk("rnd_io_sl",  io_sl,  e_sl);
    chk("rnd_io_cs",  io_cs,  e_cs);
    chk("rnd_alt_in", alt_in, m_in);
    chk("rnd_ack",    16'(bus_if.bus_ack),   16'(m_ack));
    chk("rnd_rdata",  16'(bus_if.bus_rdata), 16'(m_rdata));
  endtask

  initial begin
    hist.push_back(16'h0);
    alt_out = 16'hFFFF;
    alt_oe  = 16'hFFFF;
    io_in   = 16'h0000;
    drive(1'b1, 1'b0, 1'b0, 4'h0, 8'h00);

    //             r  w  rd  a     wd     out       oe        pu        pd        ack  rdata
    tbl[0]  = mk(1, 0, 0, 4'h0, 8'h00, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 8'h00);
    tbl[1]  = mk(0, 0, 1, 4'hC, 8'h00, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1, 8'h00);
    tbl[2]  = mk(0, 0, 1, 4'hD, 8'h00, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1, 8'h00);
    tbl[3]  = mk(0, 1, 0, 4'h2, 8'h05, 16'h0000, 16'h0005, 16'h0000, 16'h0000, 1, 8'h00);
    tbl[4]  = mk(0, 1, 0, 4'h0, 8'h04, 16'h0004, 16'h0005, 16'h0000, 16'h0000, 1, 8'h00);
    tbl[5]  = mk(0, 0, 0, 4'h0, 8'h00, 16'h0004, 16'h0005, 16'h0000, 16'h0000, 0, 8'h00);
    tbl[6]  = mk(0, 0, 1, 4'h2, 8'h00, 16'h0004, 16'h0005, 16'h0000, 16'h0000, 1, 8'h05);
    tbl[7]  = mk(0, 1, 0, 4'hD, 8'h80, 16'h8004, 16'h8005, 16'h0000, 16'h0000, 1, 8'h05);
    tbl[8]  = mk(0, 0, 1, 4'hD, 8'h00, 16'h8004, 16'h8005, 16'h0000, 16'h0000, 1, 8'h80);
    tbl[9]  = mk(0, 1, 0, 4'h2, 8'h00, 16'h8004, 16'h8000, 16'h0000, 16'h0000, 1, 8'h80);
    tbl[10] = mk(0, 1, 0, 4'h4, 8'h03, 16'h8004, 16'h8000, 16'h0003, 16'h0000, 1, 8'h80);
    tbl[11] = mk(0, 1, 0, 4'h6, 8'h03, 16'h8004, 16'h8000, 16'h0003, 16'h0000, 1, 8'h80);
    tbl[12] = mk(0, 1, 0, 4'h2, 8'h01, 16'h8004, 16'h8001, 16'h0002, 16'h0000, 1, 8'h80);
    tbl[13] = mk(0, 0, 1, 4'h4, 8'h00, 16'h8004, 16'h8001, 16'h0002, 16'h0000, 1, 8'h03);
    tbl[14] = mk(0, 1, 0, 4'h4, 8'h00, 16'h8004, 16'h8001, 16'h0000, 16'h0002, 1, 8'h03);
    tbl[15] = mk(0, 1, 1, 4'h0, 8'hF0, 16'h80F0, 16'h8001, 16'h0000, 16'h0002, 1, 8'h03);
    tbl[16] = mk(0, 0, 1, 4'h0, 8'h00, 16'h80F0, 16'h8001, 16'h0000, 16'h0002, 1, 8'hF0);
    tbl[17] = mk(0, 0, 0, 4'h0, 8'h00, 16'h80F0, 16'h8001, 16'h0000, 16'h0002, 0, 8'hF0);

    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].r, tbl[i].w, tbl[i].rd, tbl[i].a, tbl[i].wd);
      step();
      chk($sformatf("vec%0d_io_out", i), io_out, tbl[i].eo);
      chk($sformatf("vec%0d_io_oe", i),  io_oe,  tbl[i].eoe);
      chk($sformatf("vec%0d_io_ie", i),  io_ie,  ~tbl[i].eoe);
      chk($sformatf("vec%0d_io_pu", i),  io_pu,  tbl[i].epu);
      chk($sformatf("vec%0d_io_pd", i),  io_pd,  tbl[i].epd);
      chk($sformatf("vec%0d_ack", i),    16'(bus_if.bus_ack),   16'(tbl[i].eack));
      chk($sformatf("vec%0d_rdata", i),  16'(bus_if.bus_rdata), 16'(tbl[i].erd));
    end

    // Input step through the synchronizer, then read IN lo/hi.
    drive(1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
    io_in = 16'hA55A;
    step();
    chk("sync_edge1", alt_in, 16'h0000);
    step();
    chk("sync_edge2", alt_in, 16'hA55A);
    step();
    drive(1'b0, 1'b0, 1'b1, 4'hE, 8'h00);
    step();
    chk("in_lo", 16'(bus_if.bus_rdata), 16'h005A);
    drive(1'b0, 1'b0, 1'b1, 4'hF, 8'h00);
    step();
    chk("in_hi", 16'(bus_if.bus_rdata), 16'h00A5);
    chk("alt_in", alt_in, 16'hA55A);

    // Reset arriving in the ack cycle kills the ack at once.
    drive(1'b0, 1'b0, 1'b1, 4'h0, 8'h00);
    step();
    chk("ack_before_rst", 16'(bus_if.bus_ack), 16'h0001);
    drive(1'b1, 1'b0, 1'b0, 4'h0, 8'h00);
    #1;
    chk("ack_rst_cycle", 16'(bus_if.bus_ack), 16'h0000);
    step();
    chk("rst_io_ie", io_ie, 16'hFFFF);
    chk("rst_rdata", 16'(bus_if.bus_rdata), 16'h0000);

    // Reset in the strobe cycle aborts the write: no update, no ack.
    drive(1'b1, 1'b1, 1'b0, 4'h8, 8'hFF);
    step();
    chk("abort_ack0", 16'(bus_if.bus_ack), 16'h0000);
    drive(1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
    step();
    chk("abort_ack1", 16'(bus_if.bus_ack), 16'h0000);
    chk("abort_io_sl", io_sl, 16'h0000);
    drive(1'b0, 1'b0, 1'b1, 4'h8, 8'h00);
    step();
    chk("abort_sl_rd", 16'(bus_if.bus_rdata), 16'h0000);
    chk("abort_sl_ack", 16'(bus_if.bus_ack), 16'h0001);

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(0, 49) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            4'($urandom), 8'($urandom));
      alt_out = 16'($urandom);
      alt_oe  = 16'($urandom);
      io_in   = 16'($urandom);
      step();
      check_model();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
